// File: rtl/gfx_mem_pkg.sv
// Shared definitions for the frame-buffer memory arbiter.
//   OP_WR / OP_RD  : requester operation encodings
//   arb_state_e    : arbiter state encodings
//   FB_ROW_STRIDE  : frame-buffer row stride in words
package gfx_mem_pkg;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int FB_ROW_STRIDE = 240;

endpackage

// File: rtl/gfx_rd_tag_fifo.sv
// Outstanding-read tag FIFO: remembers which requester issued each read so
// returning data can be steered back to it.
//   clk, rst_        : clock, synchronous active-low reset (control only)
//   push, push_tag   : enqueue a requester index (ignored when full)
//   pop, pop_tag     : dequeue; pop_tag shows the head entry combinationally
//   full, empty      : registered occupancy flags
module gfx_rd_tag_fifo
  import gfx_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] pop_tag,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_tag = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Round-robin, burst-locked arbiter sharing one frame-buffer memory port
// among N_REQ drawing engines, with read data broadcast back by tag.
//   clk, rst_                 : clock, synchronous active-low reset
//   req_rts/rtr/wben/addr/data/op : per-requester request interface
//   bcast_data, bcast_xfc     : shared read data + one-hot owner strobe
//   mem_out_*/mem_in_rtr      : request interface towards memory
//   mem_in_rd_vld/rd_data     : read data returning from memory
//   err_spurious_rd           : sticky, read data arrived with no tag
module gfx_mem_arbiter
  import gfx_mem_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 256,
  parameter int RD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [N_REQ-1:0]      req_rts,
  output logic [N_REQ-1:0]      req_rtr,
  input  logic [4*N_REQ-1:0]    req_wben,
  input  logic [16*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]      req_op,
  output logic [31:0]           bcast_data,
  output logic [N_REQ-1:0]      bcast_xfc,
  output logic                  mem_out_rts,
  input  logic                  mem_in_rtr,
  output logic [3:0]            mem_out_wben,
  output logic [15:0]           mem_out_addr,
  output logic [31:0]           mem_out_data,
  output logic                  mem_out_op,
  input  logic                  mem_in_rd_vld,
  input  logic [31:0]           mem_in_rd_data,
  output logic                  err_spurious_rd
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   grant_idx_q, grant_idx_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;

  logic            in_grant, block, xfc, tag_push, tag_pop;
  logic            tag_full, tag_empty;
  logic [GW-1:0]   pop_tag;
  logic            sel_found;
  logic [GW-1:0]   sel_idx;
  int              g;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  assign g = int'(grant_idx_q);

  // First pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!sel_found && req_rts[idx]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  // Reads stall on the registered full flag even if a pop frees a slot now.
  assign in_grant = (state_q == ARB_GRANT);
  assign block    = in_grant & (req_op[g] == OP_RD) & tag_full;
  assign mem_out_rts  = in_grant & req_rts[g] & ~block;
  assign mem_out_wben = in_grant ? req_wben[4*g +: 4]   : '0;
  assign mem_out_addr = in_grant ? req_addr[16*g +: 16] : '0;
  assign mem_out_data = in_grant ? req_data[32*g +: 32] : '0;
  assign mem_out_op   = in_grant ? req_op[g]            : 1'b0;
  assign req_rtr      = (in_grant & mem_in_rtr & ~block) ? (N_REQ'(1) << grant_idx_q) : '0;
  assign xfc          = mem_out_rts & mem_in_rtr;

  assign tag_push   = xfc & (mem_out_op == OP_RD);
  assign tag_pop    = mem_in_rd_vld & ~tag_empty;
  assign bcast_data = tag_pop ? mem_in_rd_data : '0;
  assign bcast_xfc  = tag_pop ? (N_REQ'(1) << pop_tag) : '0;
  assign err_spurious_rd = err_q;

  gfx_rd_tag_fifo #(
    .DEPTH (RD_DEPTH),
    .TAG_W (GW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_     (rst_),
    .push     (tag_push),
    .push_tag (grant_idx_q),
    .pop      (tag_pop),
    .pop_tag  (pop_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q | (mem_in_rd_vld & tag_empty);
    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          state_d     = ARB_GRANT;
          grant_idx_d = sel_idx;
          beat_cnt_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (xfc) beat_cnt_d = beat_cnt_q + 1'b1;
        // Hand the pointer past the releasing requester so it queues behind others.
        if (!req_rts[g] || (xfc && beat_cnt_q == BW'(MAX_BURST - 1))) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_idx(grant_idx_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Randomized bench for gfx_mem_arbiter with a transaction-level reference
// model (current owner, beat count, queue of outstanding read owners).
module tb_gfx_mem_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            rst_;
  logic [N-1:0]    req_rts, req_rtr, req_op, bcast_xfc;
  logic [4*N-1:0]  req_wben;
  logic [16*N-1:0] req_addr;
  logic [32*N-1:0] req_data;
  logic [31:0]     bcast_data, mem_out_data, mem_in_rd_data;
  logic            mem_out_rts, mem_in_rtr, mem_out_op, mem_in_rd_vld, err_spurious_rd;
  logic [3:0]      mem_out_wben;
  logic [15:0]     mem_out_addr;

  always #5 clk = ~clk;

  gfx_mem_arbiter #(.N_REQ(N), .MAX_BURST(MB), .RD_DEPTH(RD)) dut (
    .clk(clk), .rst_(rst_),
    .req_rts(req_rts), .req_rtr(req_rtr), .req_wben(req_wben),
    .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
    .bcast_data(bcast_data), .bcast_xfc(bcast_xfc),
    .mem_out_rts(mem_out_rts), .mem_in_rtr(mem_in_rtr),
    .mem_out_wben(mem_out_wben), .mem_out_addr(mem_out_addr),
    .mem_out_data(mem_out_data), .mem_out_op(mem_out_op),
    .mem_in_rd_vld(mem_in_rd_vld), .mem_in_rd_data(mem_in_rd_data),
    .err_spurious_rd(err_spurious_rd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (-1 = nobody), where the next search
  // starts, beats used by the current owner, and owners of pending reads.
  int m_owner, m_ptr, m_beats;
  int m_tags[$];
  bit m_err;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_err = 1'b0;
    m_tags.delete();
  endtask

  // Entered just after the falling edge with inputs already driven; checks
  // outputs, advances the model across the rising edge, returns at the next
  // falling edge.
  task automatic run_cycle();
    logic [N-1:0] e_rtr, e_xfc;
    logic [15:0]  e_addr;
    logic [31:0]  e_data, e_bdata;
    logic [3:0]   e_wben;
    logic         e_rts, e_op, blocked, acc, ret;
    int           gi, idx;
    #1;
    e_rtr = '0; e_xfc = '0; e_addr = '0; e_data = '0; e_bdata = '0;
    e_wben = '0; e_rts = 1'b0; e_op = 1'b0; blocked = 1'b0; gi = m_owner;
    if (gi >= 0) begin
      blocked = req_op[gi] && (m_tags.size() == RD);
      e_rts   = req_rts[gi] && !blocked;
      if (mem_in_rtr && !blocked) e_rtr[gi] = 1'b1;
      e_addr = req_addr[16*gi +: 16];
      e_data = req_data[32*gi +: 32];
      e_wben = req_wben[4*gi +: 4];
      e_op   = req_op[gi];
    end
    acc = e_rts && mem_in_rtr;
    ret = mem_in_rd_vld && (m_tags.size() > 0);
    if (ret) begin
      e_xfc[m_tags[0]] = 1'b1;
      e_bdata = mem_in_rd_data;
    end
    check_val("mem_out_rts", mem_out_rts, e_rts);
    check_val("req_rtr", req_rtr, e_rtr);
    check_val("mem_out_addr", mem_out_addr, e_addr);
    check_val("mem_out_data", mem_out_data, e_data);
    check_val("mem_out_wben", mem_out_wben, e_wben);
    check_val("mem_out_op", mem_out_op, e_op);
    check_val("bcast_xfc", bcast_xfc, e_xfc);
    check_val("bcast_data", bcast_data, e_bdata);
    check_val("err_spurious_rd", err_spurious_rd, m_err);

    if (!rst_) begin
      model_reset();
    end else begin
      if (mem_in_rd_vld && m_tags.size() == 0) m_err = 1'b1;
      if (gi < 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (m_owner < 0 && req_rts[idx]) begin
            m_owner = idx;
            m_beats = 0;
          end
        end
      end else begin
        if (acc) begin
          m_beats++;
          if (req_op[gi]) m_tags.push_back(gi);
        end
        if (!req_rts[gi] || (acc && m_beats == MB)) begin
          m_owner = -1;
          m_ptr   = (gi + 1) % N;
        end
      end
      if (ret) void'(m_tags.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drive_random(input int tog, input int rd_pct, input int rtr_pct, input int rdv_pct);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(99) < tog) req_rts[i] = ~req_rts[i];
      req_op[i]            = ($urandom_range(99) < rd_pct);
      req_addr[16*i +: 16] = 16'($urandom);
      req_data[32*i +: 32] = $urandom;
      req_wben[4*i +: 4]   = 4'($urandom);
    end
    mem_in_rtr     = ($urandom_range(99) < rtr_pct);
    mem_in_rd_vld  = (m_tags.size() > 0) && ($urandom_range(99) < rdv_pct);
    mem_in_rd_data = $urandom;
  endtask

  int tog_t[3] = '{20, 3, 10};
  int rd_t[3]  = '{30, 0, 90};
  int rtr_t[3] = '{80, 70, 85};
  int rdv_t[3] = '{40, 30, 8};

  initial begin
    rst_ = 1'b0; req_rts = '0; req_op = '0; req_addr = '0; req_data = '0;
    req_wben = '0; mem_in_rtr = 1'b0; mem_in_rd_vld = 1'b0; mem_in_rd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    // Reset state: all outputs zero while held in reset
    repeat (2) begin
      req_rts = 4'b1011; mem_in_rtr = 1'b1;
      run_cycle();
    end
    req_rts = '0;
    rst_ = 1'b1;

    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 800; c++) begin
        drive_random(tog_t[p], rd_t[p], rtr_t[p], rdv_t[p]);
        run_cycle();
      end
    end

    // Leave reads outstanding, reset, then return data with no tag
    req_rts = 4'b0100; req_op = '1; mem_in_rtr = 1'b1; mem_in_rd_vld = 1'b0;
    for (int c = 0; c < 200 && m_tags.size() < 2; c++) run_cycle();
    check_val("reads_outstanding", (m_tags.size() >= 2), 1'b1);
    rst_ = 1'b0; req_rts = '0;
    run_cycle();
    rst_ = 1'b1;
    mem_in_rd_vld = 1'b1; mem_in_rd_data = 32'hDEADBEEF;
    run_cycle();
    mem_in_rd_vld = 1'b0;
    run_cycle();
    #1;
    check_val("err_sticky", err_spurious_rd, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
